// File: rtl/fifo_sync_pkg.sv
// Shared constants and the pointer-width helper for the fifo_sync block.
// clog2 is evaluated at elaboration to size pointers and the occupancy count.
package fifo_sync_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
// Read data follows raddr_i combinationally; contents are never reset.
module fifo_sync_ram
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdat_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags, ovf/udf pulses and optional FWFT read.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); writes at full and reads at empty are dropped and flagged.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             wen,
  input  logic             ren,
  output logic [WIDTH-1:0] dat_o,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] CNT_FULL  = DEPTH[AW:0];
  localparam logic [AW:0] CNT_AFULL = AFULL_TH[AW:0];
  localparam logic [AW:0] CNT_AEMPT = AEMPTY_TH[AW:0];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             ovf_q, udf_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_dat;

  // Acceptance uses the registered flags only: a same-cycle read never frees a slot at full.
  always_comb begin
    wr_acc  = wen & ~full_q;
    rd_acc  = ren & ~empty_q;
    wptr_d  = wr_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = rd_acc ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= CNT_AFULL);
      aempty_q <= (count_d <= CNT_AEMPT);
      ovf_q    <= wen & full_q;
      udf_q    <= ren & empty_q;
    end
  end

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdat_i  (dat_i),
    .raddr_i (rptr_q),
    .rdat_o  (rd_dat)
  );

  if (FWFT != 0) begin : g_fwft
    assign dat_o = rd_dat;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst_i) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= rd_dat;
      end
    end

    assign dat_o = dout_q;
  end

  assign full   = full_q;
  assign empty  = empty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a registered-read and an FWFT instance, both DEPTH=4, checked against a queue model.
module tb_fifo_sync;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] dat0 = '0, dout0;
  logic       wen0 = 1'b0, ren0 = 1'b0;
  logic       full0, empty0, afull0, aempty0, ovf0, udf0;
  logic [2:0] count0;

  logic [7:0] dat1 = '0, dout1;
  logic       wen1 = 1'b0, ren1 = 1'b0;
  logic       full1, empty1, afull1, aempty1, ovf1, udf1;
  logic [2:0] count1;

  int vectors = 0;
  int miscompares = 0;
  string ph = "reset";

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         m0_cnt = 0;
  int         m1_cnt = 0;
  logic [7:0] m0_last = '0;

  always #5 clk = ~clk;

  fifo_sync #(.WIDTH(8), .DEPTH(D), .AFULL_TH(2), .AEMPTY_TH(1), .FWFT(0)) u_reg (
    .clk(clk), .rst_i(rst), .dat_i(dat0), .wen(wen0), .ren(ren0), .dat_o(dout0),
    .full(full0), .empty(empty0), .afull(afull0), .aempty(aempty0),
    .count(count0), .ovf(ovf0), .udf(udf0)
  );

  fifo_sync #(.WIDTH(8), .DEPTH(D), .AFULL_TH(2), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_i(rst), .dat_i(dat1), .wen(wen1), .ren(ren1), .dat_o(dout1),
    .full(full1), .empty(empty1), .afull(afull1), .aempty(aempty1),
    .count(count1), .ovf(ovf1), .udf(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %0h expected %0h", ph, tag, obs, exp);
    end
  endtask

  task automatic expect0(input logic eo, input logic eu);
    chk("count0",  32'(count0),  32'(m0_cnt));
    chk("empty0",  32'(empty0),  32'(m0_cnt == 0));
    chk("full0",   32'(full0),   32'(m0_cnt == D));
    chk("afull0",  32'(afull0),  32'(m0_cnt >= 2));
    chk("aempty0", 32'(aempty0), 32'(m0_cnt <= 1));
    chk("ovf0",    32'(ovf0),    32'(eo));
    chk("udf0",    32'(udf0),    32'(eu));
    chk("dout0",   32'(dout0),   32'(m0_last));
  endtask

  task automatic expect1(input logic eo, input logic eu);
    chk("count1",  32'(count1),  32'(m1_cnt));
    chk("empty1",  32'(empty1),  32'(m1_cnt == 0));
    chk("full1",   32'(full1),   32'(m1_cnt == D));
    chk("afull1",  32'(afull1),  32'(m1_cnt >= 2));
    chk("aempty1", 32'(aempty1), 32'(m1_cnt <= 1));
    chk("ovf1",    32'(ovf1),    32'(eo));
    chk("udf1",    32'(udf1),    32'(eu));
    if (m1_cnt != 0) chk("head1", 32'(dout1), 32'(q1[0]));
  endtask

  // One clock on the registered-read instance; the model predicts acceptance from its own occupancy.
  task automatic step0(input logic w, input logic r, input logic [7:0] d);
    logic wa, ra, eo, eu;
    wa = w && (m0_cnt != D);
    ra = r && (m0_cnt != 0);
    eo = w && (m0_cnt == D);
    eu = r && (m0_cnt == 0);
    if (ra) m0_last = q0.pop_front();
    if (wa) q0.push_back(d);
    m0_cnt = m0_cnt + int'(wa) - int'(ra);
    wen0 = w; ren0 = r; dat0 = d;
    @(posedge clk); #1;
    wen0 = 1'b0; ren0 = 1'b0;
    expect0(eo, eu);
  endtask

  task automatic step1(input logic w, input logic r, input logic [7:0] d);
    logic wa, ra, eo, eu;
    wa = w && (m1_cnt != D);
    ra = r && (m1_cnt != 0);
    eo = w && (m1_cnt == D);
    eu = r && (m1_cnt == 0);
    if (ra) void'(q1.pop_front());
    if (wa) q1.push_back(d);
    m1_cnt = m1_cnt + int'(wa) - int'(ra);
    wen1 = w; ren1 = r; dat1 = d;
    @(posedge clk); #1;
    wen1 = 1'b0; ren1 = 1'b0;
    expect1(eo, eu);
  endtask

  task automatic do_reset(input int n, input logic w, input logic [7:0] d);
    rst = 1'b1;
    wen0 = w; dat0 = d;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    wen0 = 1'b0;
    q0.delete(); q1.delete();
    m0_cnt = 0; m1_cnt = 0; m0_last = '0;
    expect0(1'b0, 1'b0);
    expect1(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ph = "reset";
    do_reset(2, 1'b0, 8'h00);

    ph = "fill";
    for (int i = 1; i <= 4; i++) step0(1'b1, 1'b0, 8'(i));
    step0(1'b1, 1'b0, 8'h05);
    step0(1'b0, 1'b0, 8'h00);

    ph = "drain";
    for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b0, 8'h00);

    ph = "steady";
    step0(1'b1, 1'b0, 8'h10);
    step0(1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 12; i++) step0(1'b1, 1'b1, 8'(8'h12 + i));
    step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b1, 8'h00);

    ph = "both_edge";
    step0(1'b1, 1'b1, 8'h40);
    for (int i = 1; i < 4; i++) step0(1'b1, 1'b0, 8'(8'h40 + i));
    step0(1'b1, 1'b1, 8'h50);
    for (int i = 0; i < 3; i++) step0(1'b0, 1'b1, 8'h00);

    ph = "fwft";
    step1(1'b1, 1'b0, 8'h0A);
    step1(1'b0, 1'b0, 8'h00);
    step1(1'b0, 1'b1, 8'h00);
    step1(1'b1, 1'b0, 8'h61);
    step1(1'b1, 1'b0, 8'h62);
    step1(1'b0, 1'b1, 8'h00);
    step1(1'b0, 1'b1, 8'h00);
    step1(1'b0, 1'b1, 8'h00);

    ph = "midrst";
    for (int i = 0; i < 3; i++) step0(1'b1, 1'b0, 8'(8'h21 + i));
    do_reset(1, 1'b1, 8'h99);
    step0(1'b1, 1'b0, 8'h0B);
    step0(1'b1, 1'b0, 8'h0C);
    step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
